// File: rtl/ultrasonic_echo_meter.sv
// Ultrasonic ranger controller: fires a trigger pulse, times the echo in microseconds
// and converts it on the fly into a three-digit BCD distance in centimetres.
module ultrasonic_echo_meter #(
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned WAIT_US     = 30000,
    parameter int unsigned MAX_ECHO_US = 25000,
    parameter int unsigned US_PER_CM   = 58
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clk_usec,
    input  logic       start,
    input  logic       echo,
    output logic       trig,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [3:0] cm1,
    output logic [3:0] cm10,
    output logic [3:0] cm100
);

    localparam int unsigned SubW = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
    localparam logic [SubW-1:0] SubLast = SubW'(US_PER_CM - 1);
    localparam logic [14:0] TrigLast = 15'(TRIG_US - 1);
    localparam logic [14:0] WaitLast = 15'(WAIT_US - 1);
    localparam logic [14:0] EchoLast = 15'(MAX_ECHO_US - 1);

    typedef enum logic [2:0] {StIdle, StTrig, StWaitEcho, StMeasure, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0]      echo_sync_q;
    logic            echo_prev_q, echo_rise_q, echo_fall_q;
    logic [14:0]     usec_q, usec_d;
    logic [SubW-1:0] sub_q, sub_d;
    logic [3:0]      w1_q, w1_d, w10_q, w10_d, w100_q, w100_d;
    logic [3:0]      inc1, inc10, inc100;
    logic [3:0]      cm1_q, cm1_d, cm10_q, cm10_d, cm100_q, cm100_d;
    logic            timeout_q, timeout_d;
    logic            count_tick;

    // Edges are registered so rise and fall see the same pipeline delay.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            echo_sync_q <= 2'b00;
            echo_prev_q <= 1'b0;
            echo_rise_q <= 1'b0;
            echo_fall_q <= 1'b0;
        end else begin
            echo_sync_q <= {echo_sync_q[0], echo};
            echo_prev_q <= echo_sync_q[1];
            echo_rise_q <= echo_sync_q[1] & ~echo_prev_q;
            echo_fall_q <= ~echo_sync_q[1] & echo_prev_q;
        end
    end

    // Decimal increment of the working distance, holding at 999.
    always_comb begin
        inc1   = w1_q;
        inc10  = w10_q;
        inc100 = w100_q;
        if (!(w100_q == 4'd9 && w10_q == 4'd9 && w1_q == 4'd9)) begin
            if (w1_q == 4'd9) begin
                inc1 = 4'd0;
                if (w10_q == 4'd9) begin
                    inc10  = 4'd0;
                    inc100 = w100_q + 4'd1;
                end else begin
                    inc10 = w10_q + 4'd1;
                end
            end else begin
                inc1 = w1_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        usec_d     = usec_q;
        sub_d      = sub_q;
        w1_d       = w1_q;
        w10_d      = w10_q;
        w100_d     = w100_q;
        cm1_d      = cm1_q;
        cm10_d     = cm10_q;
        cm100_d    = cm100_q;
        timeout_d  = timeout_q;
        count_tick = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    usec_d    = '0;
                    sub_d     = '0;
                    w1_d      = 4'd0;
                    w10_d     = 4'd0;
                    w100_d    = 4'd0;
                    timeout_d = 1'b0;
                    state_d   = StTrig;
                end
            end
            StTrig: begin
                if (clk_usec) begin
                    if (usec_q == TrigLast) begin
                        usec_d  = '0;
                        state_d = StWaitEcho;
                    end else begin
                        usec_d = usec_q + 15'd1;
                    end
                end
            end
            StWaitEcho: begin
                // A tick coinciding with the detected rise belongs to the echo,
                // mirroring the fall edge dropping its coincident tick.
                if (echo_rise_q) begin
                    state_d    = StMeasure;
                    usec_d     = clk_usec ? 15'd1 : 15'd0;
                    count_tick = clk_usec;
                end else if (clk_usec) begin
                    if (usec_q == WaitLast) begin
                        timeout_d = 1'b1;
                        cm1_d     = 4'd0;
                        cm10_d    = 4'd0;
                        cm100_d   = 4'd0;
                        state_d   = StDone;
                    end else begin
                        usec_d = usec_q + 15'd1;
                    end
                end
            end
            StMeasure: begin
                if (echo_fall_q) begin
                    cm1_d   = w1_q;
                    cm10_d  = w10_q;
                    cm100_d = w100_q;
                    state_d = StDone;
                end else if (clk_usec) begin
                    if (usec_q == EchoLast) begin
                        timeout_d = 1'b1;
                        cm1_d     = 4'd0;
                        cm10_d    = 4'd0;
                        cm100_d   = 4'd0;
                        state_d   = StDone;
                    end else begin
                        usec_d     = usec_q + 15'd1;
                        count_tick = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (count_tick) begin
            if (sub_q == SubLast) begin
                sub_d  = '0;
                w1_d   = inc1;
                w10_d  = inc10;
                w100_d = inc100;
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= StIdle;
            usec_q    <= '0;
            sub_q     <= '0;
            w1_q      <= 4'd0;
            w10_q     <= 4'd0;
            w100_q    <= 4'd0;
            cm1_q     <= 4'd0;
            cm10_q    <= 4'd0;
            cm100_q   <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            usec_q    <= usec_d;
            sub_q     <= sub_d;
            w1_q      <= w1_d;
            w10_q     <= w10_d;
            w100_q    <= w100_d;
            cm1_q     <= cm1_d;
            cm10_q    <= cm10_d;
            cm100_q   <= cm100_d;
            timeout_q <= timeout_d;
        end
    end

    assign trig    = (state_q == StTrig);
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign timeout = timeout_q;
    assign cm1     = cm1_q;
    assign cm10    = cm10_q;
    assign cm100   = cm100_q;

endmodule
